paddle_cmd_gen: RTL and testbench
=================================

# paddle_cmd_gen

Producer side of the paddle move-command interface. Receives PS/2 keyboard frames, decodes the left-arrow and right-arrow make/break sequences, and tracks which arrow is held. While exactly one arrow is held, it emits rate-limited move strobes as `cmd`/`cmd_en`; these connect directly to the paddle block's `in`/`inEnable`. It sits between the keyboard pins and the paddle, in the system clock domain.

## Interface
- `REPEAT_CYCLES`, default 500000: clock cycles between successive move strobes while a key is held; legal range ≥2.
- `FRAME_TIMEOUT`, default 50000: idle cycles after which a partial PS/2 frame is discarded.
- `clock`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous.
- `ps2_dat`  in  1  raw PS/2 data, asynchronous.
- `cmd`  out  8  move code: 8'h00 means right, 8'h01 means left; reset value 8'hFF.
- `cmd_en`  out  1  single-cycle move strobe; reset value 0.
- `held`  out  2  debug: {left_held, right_held}; reset value 2'b00.
- `frame_err`  out  1  one-cycle pulse on a parity, start, stop or timeout error; reset value 0.

## Operation
- **Input conditioning:** `ps2_clk` and `ps2_dat` each pass through a 2-flop synchronizer. A falling edge is detected on the synchronized clock.
- **Frame receiver:** shifts an 11-bit frame, one bit per falling edge: start=0, then 8 data bits LSB first, then odd parity, then stop=1.
  - A valid frame produces a `byte_valid` pulse with `byte_data`.
  - Start≠0, bad parity, or stop≠1: drop the byte and pulse `frame_err`.
  - `FRAME_TIMEOUT` cycles with no falling edge in mid-frame: reset the bit counter and pulse `frame_err`.
- **Decoder FSM:** states IDLE, EXT, BRK, EXT_BRK. It acts only on `byte_valid`.
  - IDLE: E0 goes to EXT; F0 goes to BRK; any other byte stays in IDLE (non-extended keys are ignored).
  - EXT: F0 goes to EXT_BRK. 6B sets left_held and returns to IDLE. 74 sets right_held and returns to IDLE. Any other byte returns to IDLE.
  - BRK: any byte returns to IDLE (non-extended break, ignored).
  - EXT_BRK: 6B clears left_held, 74 clears right_held, any other byte changes nothing; always returns to IDLE.
  - A repeated make code (typematic) while a key is already held only re-sets the held bit; it does not restart the rate counter.
- **Move generation:** active = left_held XOR right_held.
  - When active rises (0→1, or the direction changes), assert `cmd_en` immediately and reload the rate counter to `REPEAT_CYCLES-1`.
  - While active, the counter decrements each cycle. At 0 it asserts `cmd_en` and reloads.
  - Not active (neither or both held): `cmd_en`=0 and the counter is held at the reload value.
  - `cmd` is updated in the same cycle as each `cmd_en` and holds its value between strobes.
- **Reset:** mid-frame or mid-sequence, reset returns everything to its reset values. The FSM goes to IDLE, the bit counter clears, and held keys are forgotten.

## Timing
- Pin to byte: 2 synchronizer cycles plus 1 edge-detect cycle after the 11th falling edge, then `byte_valid` is registered.
- Byte to held: held bits update on the cycle after `byte_valid`.
- Held to first strobe: `cmd_en` is high on the cycle after the held change.
- Repeat: successive strobes are exactly `REPEAT_CYCLES` cycles apart; `cmd_en` is never high on two consecutive cycles.
- Direction change (e.g. right released, left pressed): the first left strobe follows the left make code by one cycle, regardless of the counter phase.
- Simultaneous events (a strobe due in the same cycle the key is released): the release wins and no strobe is issued.

## Structure
- Shared package `brick_pkg`:
  - Scan-code constants SC_EXT=8'hE0, SC_BRK=8'hF0, SC_LEFT=8'h6B, SC_RIGHT=8'h74.
  - Command codes CMD_RIGHT=8'h00, CMD_LEFT=8'h01, CMD_NONE=8'hFF.
  - Decoder state encoding.
- Sub-module `ps2_rx`: synchronizers, edge detect, shift register, parity/timeout checks. Outputs `byte_valid`, `byte_data`, `frame_err`.
- Top level: decoder FSM, held-key registers, rate counter.

## Test plan
All scenarios use REPEAT_CYCLES=4 and FRAME_TIMEOUT=100.
- **Right hold:** frames E0, 74 → `held`=2'b01; `cmd_en` one cycle later with `cmd`=00, then every 4 cycles. Then frames E0, F0, 74 → strobes stop and `held`=00.
- **Left hold with typematic:** E0 6B, then E0 6B repeated → `cmd`=01 with strobes every 4 cycles; the repeat does not shift the strobe phase.
- **Both held:** E0 74, then E0 6B → `held`=11 and no `cmd_en`. Then release right (E0 F0 74) → a left strobe on the next cycle, then every 4 cycles.
- **Parity error:** frame with wrong parity for 74 → `frame_err` pulse; `held` unchanged; no strobe.
- **Timeout:** 5 bits of a frame then 100 idle cycles → `frame_err`. A subsequent clean E0 74 is decoded correctly.
- **Reset during hold:** `reset` asserted while right is held → next cycle `cmd`=FF, `cmd_en`=0, `held`=00, FSM in IDLE.

Source files
------------

// File: rtl/brick_pkg.sv
// Shared constants for the keyboard-to-paddle path: PS/2 scan codes,
// paddle move codes and the scan-code decoder state encoding.
package brick_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam logic [7:0] CMD_RIGHT = 8'h00;
    localparam logic [7:0] CMD_LEFT  = 8'h01;
    localparam logic [7:0] CMD_NONE  = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } dec_state_e;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizes the raw pins, shifts in 11-bit frames on
// falling PS/2 clock edges and reports good bytes or framing errors.
module ps2_rx #(
    parameter int FRAME_TIMEOUT = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int TW = $clog2(FRAME_TIMEOUT + 1);

    logic          clk_s1_q, clk_s2_q, clk_prev_q;
    logic          dat_s1_q, dat_s2_q;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          byte_valid_q, byte_valid_d;
    logic [7:0]    byte_data_q, byte_data_d;
    logic          frame_err_q, frame_err_d;
    logic          fall;

    // Synchronizers idle high so leaving reset never looks like a clock edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_s1_q     <= 1'b1;
            clk_s2_q     <= 1'b1;
            clk_prev_q   <= 1'b1;
            dat_s1_q     <= 1'b1;
            dat_s2_q     <= 1'b1;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            timer_q      <= '0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            clk_s1_q     <= ps2_clk;
            clk_s2_q     <= clk_s1_q;
            clk_prev_q   <= clk_s2_q;
            dat_s1_q     <= ps2_dat;
            dat_s2_q     <= dat_s1_q;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            timer_q      <= timer_d;
            byte_valid_q <= byte_valid_d;
            byte_data_q  <= byte_data_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // After ten shifts: shift_q[0]=start, [8:1]=data, [9]=parity; the stop
    // bit is checked live on the eleventh edge.
    always_comb begin
        fall         = clk_prev_q & ~clk_s2_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        timer_d      = timer_q;
        byte_valid_d = 1'b0;
        byte_data_d  = byte_data_q;
        frame_err_d  = 1'b0;
        if (fall) begin
            timer_d = '0;
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = '0;
                if (!shift_q[0] && dat_s2_q && (^shift_q[9:1])) begin
                    byte_valid_d = 1'b1;
                    byte_data_d  = shift_q[8:1];
                end else begin
                    frame_err_d = 1'b1;
                end
            end else begin
                shift_d   = {dat_s2_q, shift_q[9:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (timer_q == TW'(FRAME_TIMEOUT - 1)) begin
                timer_d     = '0;
                bit_cnt_d   = '0;
                frame_err_d = 1'b1;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;
    assign frame_err  = frame_err_q;

endmodule

// File: rtl/paddle_cmd_gen.sv
// Turns PS/2 arrow-key make/break sequences into rate-limited paddle move
// strobes; strobes repeat only while exactly one arrow is held.
module paddle_cmd_gen
    import brick_pkg::*;
#(
    parameter int REPEAT_CYCLES = 500000,
    parameter int FRAME_TIMEOUT = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] cmd,
    output logic       cmd_en,
    output logic [1:0] held,
    output logic       frame_err
);

    localparam int             CW     = $clog2(REPEAT_CYCLES);
    localparam logic [CW-1:0]  RELOAD = CW'(REPEAT_CYCLES - 1);

    logic          byte_valid;
    logic [7:0]    byte_data;
    dec_state_e    state_q, state_d;
    logic          left_q, left_d, right_q, right_d;
    logic [1:0]    last_held_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    cmd_q, cmd_d;
    logic          cmd_en_q, cmd_en_d;
    logic          active, rise;

    ps2_rx #(.FRAME_TIMEOUT(FRAME_TIMEOUT)) u_rx (
        .clock      (clock),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            left_q      <= 1'b0;
            right_q     <= 1'b0;
            last_held_q <= 2'b00;
            cnt_q       <= RELOAD;
            cmd_q       <= CMD_NONE;
            cmd_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            left_q      <= left_d;
            right_q     <= right_d;
            last_held_q <= {left_q, right_q};
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            cmd_en_q    <= cmd_en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        left_d  = left_q;
        right_d = right_q;
        if (byte_valid) begin
            case (state_q)
                IDLE: begin
                    if (byte_data == SC_EXT)      state_d = EXT;
                    else if (byte_data == SC_BRK) state_d = BRK;
                end
                EXT: begin
                    state_d = IDLE;
                    if (byte_data == SC_BRK)        state_d = EXT_BRK;
                    else if (byte_data == SC_LEFT)  left_d  = 1'b1;
                    else if (byte_data == SC_RIGHT) right_d = 1'b1;
                end
                EXT_BRK: begin
                    state_d = IDLE;
                    if (byte_data == SC_LEFT)       left_d  = 1'b0;
                    else if (byte_data == SC_RIGHT) right_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A change in the held pattern that leaves one key active strobes at once,
    // so a typematic repeat (no change) keeps the running phase.
    always_comb begin
        active   = left_q ^ right_q;
        rise     = active && ({left_q, right_q} != last_held_q);
        cnt_d    = RELOAD;
        cmd_en_d = 1'b0;
        cmd_d    = cmd_q;
        if (active) begin
            if (rise || cnt_q == '0) begin
                cmd_en_d = 1'b1;
                cmd_d    = left_q ? CMD_LEFT : CMD_RIGHT;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    assign cmd    = cmd_q;
    assign cmd_en = cmd_en_q;
    assign held   = {left_q, right_q};

endmodule

// File: tb/tb_paddle_cmd_gen.sv
// Drives PS/2 frames into paddle_cmd_gen and compares every cycle against a
// key-level model of held arrows and strobe timing.
module tb_paddle_cmd_gen;

    localparam int R  = 4;
    localparam int FT = 100;

    logic       clock = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] cmd;
    logic       cmd_en;
    logic [1:0] held;
    logic       frame_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fe_seen = 0, fe_exp = 0, en_seen = 0;

    logic [1:0] want_held = 2'b00;
    logic [1:0] m_held = 2'b00, m_prev = 2'b00;
    logic       m_en = 1'b0;
    logic [7:0] m_cmd = 8'hFF;
    int         m_last = 0;
    bit         sched_arm = 1'b0;
    int         sched_cyc = 0;
    logic [1:0] sched_held = 2'b00;

    logic [7:0] junk_tbl [4] = '{8'h1C, 8'h29, 8'h75, 8'h5A};

    paddle_cmd_gen #(.REPEAT_CYCLES(R), .FRAME_TIMEOUT(FT)) dut (
        .clock     (clock),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .cmd       (cmd),
        .cmd_en    (cmd_en),
        .held      (held),
        .frame_err (frame_err)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Strobe rule: one key active and either it just became so, or R cycles
    // have passed since the previous strobe.
    always @(posedge clock) begin
        cyc = cyc + 1;
        if (reset) begin
            m_held = 2'b00; m_prev = 2'b00; m_en = 1'b0; m_cmd = 8'hFF;
            m_last = cyc; sched_arm = 1'b0;
        end else begin
            m_en = (m_held[1] ^ m_held[0]) && ((m_held != m_prev) || (cyc - m_last == R));
            if (m_en) begin
                m_last = cyc;
                m_cmd  = m_held[1] ? 8'h01 : 8'h00;
            end
            m_prev = m_held;
            if (sched_arm && cyc == sched_cyc) begin
                m_held    = sched_held;
                sched_arm = 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        if (cyc >= 1) begin
            checkOutput("cmd_en", cmd_en, m_en);
            checkOutput("cmd", cmd, m_cmd);
            checkOutput("held", held, m_held);
            if (frame_err) fe_seen++;
            if (cmd_en) en_seen++;
        end
    end

    // Held bits are expected four cycles after the final falling PS/2 edge.
    task automatic applyStimulus(input logic [7:0] b, input bit bad_par, input bit arm, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clock); ps2_dat = fr[i];
            repeat (2) @(negedge clock);
            ps2_clk = 1'b0;
            if (i == 10 && arm) begin
                sched_held = want_held;
                sched_cyc  = cyc + 4;
                sched_arm  = 1'b1;
            end
            repeat (4) @(negedge clock);
            ps2_clk = 1'b1;
        end
        repeat (6) @(negedge clock);
        if (bad_par) fe_exp++;
    endtask

    task automatic pressKey(input bit left);
        want_held[left] = 1'b1;
        applyStimulus(8'hE0, 1'b0, 1'b0, 11);
        applyStimulus(left ? 8'h6B : 8'h74, 1'b0, 1'b1, 11);
    endtask

    task automatic releaseKey(input bit left);
        want_held[left] = 1'b0;
        applyStimulus(8'hE0, 1'b0, 1'b0, 11);
        applyStimulus(8'hF0, 1'b0, 1'b0, 11);
        applyStimulus(left ? 8'h6B : 8'h74, 1'b0, 1'b1, 11);
    endtask

    task automatic pulseReset();
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        want_held = 2'b00;
    endtask

    initial begin
        int s;
        int act;
        logic [7:0] jb;
        reset = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1;
        repeat (4) @(negedge clock);
        checkOutput("reset_held", held, 2'b00);
        checkOutput("reset_cmd", cmd, 8'hFF);
        checkOutput("reset_en", cmd_en, 1'b0);
        reset = 1'b0;

        pressKey(1'b0);
        checkOutput("right_held", held, 2'b01);
        checkOutput("right_cmd", cmd, 8'h00);
        s = en_seen; repeat (20) @(negedge clock);
        checkOutput("right_rate", en_seen - s, 5);
        releaseKey(1'b0);
        checkOutput("right_rel", held, 2'b00);
        s = en_seen; repeat (10) @(negedge clock);
        checkOutput("rel_quiet", en_seen - s, 0);

        pressKey(1'b1);
        repeat (7) @(negedge clock);
        pressKey(1'b1);
        checkOutput("left_typ_held", held, 2'b10);
        checkOutput("left_cmd", cmd, 8'h01);
        releaseKey(1'b1);

        pressKey(1'b0);
        pressKey(1'b1);
        checkOutput("both_held", held, 2'b11);
        s = en_seen; repeat (12) @(negedge clock);
        checkOutput("both_quiet", en_seen - s, 0);
        releaseKey(1'b0);
        checkOutput("both_left", held, 2'b10);
        checkOutput("both_cmd", cmd, 8'h01);
        releaseKey(1'b1);

        applyStimulus(8'h74, 1'b1, 1'b0, 11);
        checkOutput("parity_fe", fe_seen, fe_exp);
        checkOutput("parity_held", held, 2'b00);

        applyStimulus(8'hE0, 1'b0, 1'b0, 5);
        repeat (130) @(negedge clock);
        fe_exp++;
        checkOutput("timeout_fe", fe_seen, fe_exp);
        pressKey(1'b0);
        checkOutput("after_to_held", held, 2'b01);

        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("rst_hold_held", held, 2'b00);
        checkOutput("rst_hold_cmd", cmd, 8'hFF);
        checkOutput("rst_hold_en", cmd_en, 1'b0);
        reset = 1'b0;
        want_held = 2'b00;
        pressKey(1'b1);
        checkOutput("post_rst_held", held, 2'b10);

        applyStimulus(8'hE0, 1'b0, 1'b0, 5);
        pulseReset();
        pressKey(1'b0);
        checkOutput("midframe_rst", held, 2'b01);

        for (int n = 0; n < 40; n++) begin
            act = int'($urandom_range(0, 8));
            jb  = junk_tbl[$urandom_range(0, 3)];
            case (act)
                0: pressKey(1'b1);
                1: releaseKey(1'b1);
                2: pressKey(1'b0);
                3: releaseKey(1'b0);
                4: applyStimulus(jb, 1'b0, 1'b0, 11);
                5: begin
                    applyStimulus(8'hF0, 1'b0, 1'b0, 11);
                    applyStimulus(jb, 1'b0, 1'b0, 11);
                end
                6: begin
                    applyStimulus(8'hE0, 1'b0, 1'b0, 11);
                    if ($urandom_range(0, 1) == 1) applyStimulus(8'hF0, 1'b0, 1'b0, 11);
                    applyStimulus(jb, 1'b0, 1'b0, 11);
                end
                7: applyStimulus(8'($urandom), 1'b1, 1'b0, 11);
                default: pulseReset();
            endcase
            repeat ($urandom_range(0, 15)) @(negedge clock);
        end
        repeat (10) @(negedge clock);
        checkOutput("frame_err_total", fe_seen, fe_exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
